// File: rtl/key_link_pkg.sv
// ---------------------------------------------------------------------------
// key_link_pkg
//   Constants and types shared by the key link transmitter, the nibble
//   receiver and their benches.
//   Frame on the wire: START_LVL, d0..d3 (LSB first), STOP_LVL.
//   The line rests at IDLE_LVL between frames.
// ---------------------------------------------------------------------------
package key_link_pkg;

    localparam int   DATA_BITS = 4;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;
    localparam int   FRAME_LEN = 6;

    // Transmitter FSM encoding.
    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_STOP  = 3'd3,
        TX_GAP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/key_nibble_fifo.sv
// ---------------------------------------------------------------------------
// key_nibble_fifo
//   DEPTH x DATA_BITS synchronous FIFO with registered occupancy.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset (control only)
//     push_i        write data_i at the tail (ignored while full)
//     data_i        nibble to store
//     pop_i         advance the head (ignored while empty)
//     data_o        current head entry
//     count_o       occupancy, 0..DEPTH
//     full_o        count_o == DEPTH
//     empty_o       count_o == 0
// ---------------------------------------------------------------------------
module key_nibble_fifo
    import key_link_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [DATA_BITS-1:0]   data_i,
    input  logic                   pop_i,
    output logic [DATA_BITS-1:0]   data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [AW:0]          count_q;
    logic                 do_push;
    logic                 do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/key_nibble_tx.sv
// ---------------------------------------------------------------------------
// key_nibble_tx
//   Buffers 4-bit key codes and serializes each one as
//   start(0), d0..d3 (LSB first), stop(1), followed by GAP idle-high cycles.
//   Back-to-back frames run without any idle bit when GAP is 0.
//   Ports:
//     clk, rst    clock, asynchronous active-high reset
//     i_valid     producer offers i_nibble
//     i_nibble    key code
//     o_ready     FIFO not full (from registered occupancy)
//     o_tx_bit    registered serial line, idles high
//     o_busy      FSM outside IDLE
//     o_count     FIFO occupancy
//     o_drop      sticky: a nibble was offered while the FIFO was full
// ---------------------------------------------------------------------------
module key_nibble_tx
    import key_link_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int GAP   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic [3:0]             i_nibble,
    output logic                   o_ready,
    output logic                   o_tx_bit,
    output logic                   o_busy,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_drop
);

    localparam int IW = $clog2(DATA_BITS);
    localparam int GW = 4;

    tx_state_e            state_q;
    logic [DATA_BITS-1:0] sh_q;
    logic [IW-1:0]        bit_idx_q;
    logic [GW-1:0]        gap_cnt_q;
    logic                 tx_q;
    logic                 drop_q;

    logic [DATA_BITS-1:0] fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;

    key_nibble_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (i_valid),
        .data_i  (i_nibble),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .count_o (o_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A new frame may begin from IDLE, straight out of STOP when there is
    // no gap, or from the last GAP cycle. Occupancy is registered, so a
    // nibble pushed on this edge is never the one popped on it.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty) begin
            case (state_q)
                TX_IDLE: pop = 1'b1;
                TX_STOP: pop = (GAP == 0);
                TX_GAP:  pop = (gap_cnt_q == '0);
                default: pop = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= TX_IDLE;
            tx_q      <= IDLE_LVL;
            bit_idx_q <= '0;
            gap_cnt_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            if (i_valid && fifo_full) drop_q <= 1'b1;

            case (state_q)
                TX_IDLE: begin
                    tx_q <= IDLE_LVL;
                    if (pop) begin
                        tx_q    <= START_LVL;
                        state_q <= TX_START;
                    end
                end
                TX_START: begin
                    tx_q      <= sh_q[0];
                    bit_idx_q <= '0;
                    state_q   <= TX_DATA;
                end
                TX_DATA: begin
                    if (bit_idx_q == IW'(DATA_BITS - 1)) begin
                        tx_q    <= STOP_LVL;
                        state_q <= TX_STOP;
                    end else begin
                        tx_q      <= sh_q[bit_idx_q + IW'(1)];
                        bit_idx_q <= bit_idx_q + IW'(1);
                    end
                end
                TX_STOP: begin
                    tx_q <= STOP_LVL;
                    if (GAP > 0) begin
                        gap_cnt_q <= GW'(GAP - 1);
                        state_q   <= TX_GAP;
                    end else if (pop) begin
                        tx_q    <= START_LVL;
                        state_q <= TX_START;
                    end else begin
                        state_q <= TX_IDLE;
                    end
                end
                TX_GAP: begin
                    tx_q <= IDLE_LVL;
                    if (gap_cnt_q == '0) begin
                        if (pop) begin
                            tx_q    <= START_LVL;
                            state_q <= TX_START;
                        end else begin
                            state_q <= TX_IDLE;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GW'(1);
                    end
                end
                default: begin
                    tx_q    <= IDLE_LVL;
                    state_q <= TX_IDLE;
                end
            endcase
        end
    end

    // Shift register is pure data: loaded with the head whenever a frame
    // begins, no reset needed.
    always_ff @(posedge clk) begin
        if (pop) sh_q <= fifo_head;
    end

    assign o_tx_bit = tx_q;
    assign o_busy   = (state_q != TX_IDLE);
    assign o_ready  = !fifo_full;
    assign o_drop   = drop_q;

endmodule

// File: tb/tb_key_nibble_tx.sv
// ---------------------------------------------------------------------------
// tb_key_nibble_tx
//   Two instances: u_dut0 (DEPTH=4, GAP=0) under a frame-decoding
//   scoreboard, u_dut3 (DEPTH=4, GAP=3) checked cycle by cycle.
// ---------------------------------------------------------------------------
module tb_key_nibble_tx;
    import key_link_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v0 = 1'b0, v3 = 1'b0;
    logic [3:0] n0 = '0, n3 = '0;
    logic       rdy0, tx0, busy0, drop0;
    logic       rdy3, tx3, busy3, drop3;
    logic [2:0] cnt0, cnt3;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    logic [3:0] exp_q [$];
    int         start_q [$];
    logic [23:0] key_buf = '0;
    int         mon_st = 0;
    int         mon_bits = 0;
    logic [3:0] mon_nib = '0;
    logic [3:0] mon_exp;

    key_nibble_tx #(.DEPTH(4), .GAP(0)) u_dut0 (
        .clk(clk), .rst(rst), .i_valid(v0), .i_nibble(n0),
        .o_ready(rdy0), .o_tx_bit(tx0), .o_busy(busy0),
        .o_count(cnt0), .o_drop(drop0)
    );

    key_nibble_tx #(.DEPTH(4), .GAP(3)) u_dut3 (
        .clk(clk), .rst(rst), .i_valid(v3), .i_nibble(n3),
        .o_ready(rdy3), .o_tx_bit(tx3), .o_busy(busy3),
        .o_count(cnt3), .o_drop(drop3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one nibble on one edge; acc is whether the FIFO must take it.
    task automatic send(input int which, input logic [3:0] nib, input logic acc);
        if (which == 0) begin
            chk("ready0", rdy0, acc);
            v0 = 1'b1;
            n0 = nib;
            if (acc) exp_q.push_back(nib);
        end else begin
            chk("ready3", rdy3, acc);
            v3 = 1'b1;
            n3 = nib;
        end
        step();
        v0 = 1'b0;
        v3 = 1'b0;
    endtask

    // Frame decoder on u_dut0's line, acting as the downstream receiver.
    always @(negedge clk) begin
        if (rst) begin
            mon_st   = 0;
            mon_bits = 0;
        end else begin
            case (mon_st)
                0: if (tx0 == START_LVL) begin
                    mon_st   = 1;
                    mon_bits = 0;
                    start_q.push_back(cyc);
                end
                1: begin
                    mon_nib[mon_bits] = tx0;
                    mon_bits++;
                    if (mon_bits == DATA_BITS) mon_st = 2;
                end
                default: begin
                    chk("stop_bit", tx0, STOP_LVL);
                    if (exp_q.size() == 0) begin
                        chk("sb_extra_frame", exp_q.size(), 1);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        chk("sb_nibble", mon_nib, mon_exp);
                    end
                    key_buf = {key_buf[19:0], mon_nib};
                    mon_st = 0;
                end
            endcase
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  l1;
        logic [7:0]  b1;
        logic [17:0] lg;
        int          peak;
        int          zeros;

        // Reset values, while held and after release
        step();
        step();
        chk("rst_tx", tx0, 1);
        chk("rst_busy", busy0, 0);
        chk("rst_count", cnt0, 0);
        chk("rst_ready", rdy0, 1);
        chk("rst_drop", drop0, 0);
        #3 rst = 1'b0;
        step();
        chk("idle_tx", tx0, 1);
        chk("idle_count", cnt0, 0);

        // Single nibble 4'hA
        l1 = 8'b1110_1001;
        b1 = 8'b0111_1110;
        send(0, 4'hA, 1);
        chk("single_count_e0", cnt0, 1);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            if (k == 1) chk("single_count_e1", cnt0, 0);
            chk($sformatf("single_line_k%0d", k), tx0, l1[k]);
            chk($sformatf("single_busy_k%0d", k), busy0, b1[k]);
        end

        // Burst 1..4
        start_q.delete();
        send(0, 4'h1, 1);
        send(0, 4'h2, 1);
        send(0, 4'h3, 1);
        send(0, 4'h4, 1);
        peak = int'(cnt0);
        for (int k = 0; k < 30; k++) begin
            step();
            if (int'(cnt0) > peak) peak = int'(cnt0);
        end
        chk("burst_peak", peak, 3);
        chk("burst_drop", drop0, 0);
        chk("burst_frames", start_q.size(), 4);
        for (int i = 1; i < start_q.size(); i++)
            chk($sformatf("burst_period%0d", i), start_q[i] - start_q[i-1], FRAME_LEN);

        // Overflow while the line is busy
        send(0, 4'h7, 1);
        send(0, 4'h8, 1);
        send(0, 4'h9, 1);
        send(0, 4'hA, 1);
        send(0, 4'hB, 1);
        chk("ovf_drop_before", drop0, 0);
        send(0, 4'hC, 0);
        chk("ovf_drop_set", drop0, 1);
        send(0, 4'hD, 0);
        repeat (40) step();
        chk("ovf_drained", exp_q.size(), 0);
        chk("ovf_drop_sticky", drop0, 1);

        // GAP=3 instance: 4'h5 then 4'hC
        lg = 18'b11_1110_0011_1101_0101;
        send(1, 4'h5, 1);
        chk("gap_line_k0", tx3, lg[0]);
        send(1, 4'hC, 1);
        chk("gap_line_k1", tx3, lg[1]);
        for (int k = 2; k < 18; k++) begin
            step();
            chk($sformatf("gap_line_k%0d", k), tx3, lg[k]);
        end
        chk("gap_busy_k17", busy3, 1);
        chk("gap_count_k17", cnt3, 0);
        chk("gap_drop", drop3, 0);
        repeat (4) step();

        // Reset during d2 of 4'hF with two nibbles queued
        send(0, 4'hF, 1);
        send(0, 4'h3, 1);
        send(0, 4'h6, 1);
        step();
        step();
        chk("mid_busy", busy0, 1);
        chk("mid_count", cnt0, 2);
        #2 rst = 1'b1;
        #1;
        chk("arst_tx", tx0, 1);
        chk("arst_count", cnt0, 0);
        chk("arst_busy", busy0, 0);
        chk("arst_ready", rdy0, 1);
        chk("arst_drop", drop0, 0);
        exp_q.delete();
        @(posedge clk);
        #3 rst = 1'b0;
        zeros = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (tx0 == 1'b0) zeros++;
        end
        chk("post_rst_zeros", zeros, 0);
        chk("post_rst_count", cnt0, 0);

        // Receiver-style loopback of 1..6
        key_buf = '0;
        for (int i = 1; i <= 6; i++) begin
            send(0, 4'(i), 1);
            repeat (3) step();
        end
        repeat (40) step();
        chk("loop_key", key_buf, 24'h123456);
        chk("loop_drained", exp_q.size(), 0);
        chk("loop_drop", drop0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
